// File: rtl/spi_flash_arbiter.sv
// Shares the config SPI flash pins between the JTAG-to-SPI bridge and a fabric SPI master,
// with a csn-high guard on every ownership change. Optional JTAG preemption: `define JTAG_PREEMPT_EN.
module spi_flash_arbiter #(
   parameter int GUARD_CYCLES = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int USER_TIMEOUT = 65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       jtag_csn,
   input  logic       jtag_sck,
   input  logic       jtag_sdi,
   output logic       jtag_sdo,
   input  logic       usr_req,
   output logic       usr_gnt,
   output logic       usr_abort,
   input  logic       usr_csn,
   input  logic       usr_sck,
   input  logic       usr_sdi,
   output logic       usr_sdo,
   input  logic       collision_clr,
   output logic       jtag_collision,
   output logic [1:0] owner,
   output logic       csn,
   output logic       sck,
   output logic       sdi_dq0,
   input  logic       sdo_dq1,
   output logic       wpn_dq2,
   output logic       hldn_dq3
);

   // state      | meaning
   // ST_IDLE    | parked on the JTAG path, nobody active
   // ST_JTAG    | bridge transaction in progress
   // ST_GUARD_U | user requested; JTAG path still routed while guard counts down
   // ST_USER    | fabric master owns the pins
   // ST_GUARD_J | pins forced idle (csn high) after user release
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_JTAG    = 3'd1,
      ST_GUARD_U = 3'd2,
      ST_USER    = 3'd3,
      ST_GUARD_J = 3'd4
   } state_t;

   localparam logic [7:0]  GUARD_LOAD = 8'(GUARD_CYCLES - 1);
   localparam logic [15:0] TMO_LAST   = 16'(USER_TIMEOUT - 1);
   localparam bit          TMO_EN     = (USER_TIMEOUT != 0);
`ifdef JTAG_PREEMPT_EN
   localparam bit          PREEMPT    = 1'b1;
`else
   localparam bit          PREEMPT    = 1'b0;
`endif

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   jtag_req_s;
   logic [7:0]             guard_cnt, guard_cnt_nxt;
   logic [15:0]            tmo_cnt, tmo_cnt_nxt;
   logic                   tmo_expired;
   logic                   abort_nxt;

   assign jtag_req_s  = ~sync_q[SYNC_STAGES-1];
   assign tmo_expired = TMO_EN && (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         sync_q         <= '1;
         guard_cnt      <= '0;
         tmo_cnt        <= '0;
         usr_abort      <= 1'b0;
         jtag_collision <= 1'b0;
      end else begin
         state     <= state_nxt;
         sync_q    <= {sync_q[SYNC_STAGES-2:0], jtag_csn};
         guard_cnt <= guard_cnt_nxt;
         tmo_cnt   <= tmo_cnt_nxt;
         usr_abort <= abort_nxt;
         // a new collision outranks a simultaneous clear
         if (jtag_req_s && (state == ST_USER || state == ST_GUARD_J))
            jtag_collision <= 1'b1;
         else if (collision_clr)
            jtag_collision <= 1'b0;
      end
   end

   always_comb begin
      state_nxt     = state;
      guard_cnt_nxt = guard_cnt;
      tmo_cnt_nxt   = tmo_cnt;
      abort_nxt     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (jtag_req_s) begin
               state_nxt = ST_JTAG;
            end else if (usr_req) begin
               state_nxt     = ST_GUARD_U;
               guard_cnt_nxt = GUARD_LOAD;
            end
         end
         ST_JTAG: begin
            if (!jtag_req_s)
               state_nxt = ST_IDLE;
         end
         ST_GUARD_U: begin
            if (jtag_req_s) begin
               state_nxt = ST_JTAG;
            end else if (!usr_req) begin
               state_nxt = ST_IDLE;
            end else if (guard_cnt == 8'd0) begin
               state_nxt   = ST_USER;
               tmo_cnt_nxt = 16'd0;
            end else begin
               guard_cnt_nxt = guard_cnt - 8'd1;
            end
         end
         ST_USER: begin
            if (!usr_req) begin
               state_nxt     = ST_GUARD_J;
               guard_cnt_nxt = GUARD_LOAD;
            end else if ((PREEMPT && jtag_req_s) || tmo_expired) begin
               state_nxt     = ST_GUARD_J;
               guard_cnt_nxt = GUARD_LOAD;
               abort_nxt     = 1'b1;
            end else begin
               tmo_cnt_nxt = tmo_cnt + 16'd1;
            end
         end
         ST_GUARD_J: begin
            if (guard_cnt == 8'd0)
               state_nxt = ST_IDLE;
            else
               guard_cnt_nxt = guard_cnt - 8'd1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // JTAG routing is purely combinational so the unstallable bridge sees zero latency
   always_comb begin
      csn      = jtag_csn;
      sck      = jtag_sck;
      sdi_dq0  = jtag_sdi;
      owner    = 2'b01;
      usr_gnt  = 1'b0;
      jtag_sdo = sdo_dq1;
      usr_sdo  = 1'b0;
      case (state)
         ST_USER: begin
            csn      = usr_csn;
            sck      = usr_sck;
            sdi_dq0  = usr_sdi;
            owner    = 2'b10;
            usr_gnt  = 1'b1;
            jtag_sdo = 1'b0;
            usr_sdo  = sdo_dq1;
         end
         ST_GUARD_J: begin
            csn      = 1'b1;
            sck      = 1'b0;
            sdi_dq0  = 1'b0;
            owner    = 2'b00;
            jtag_sdo = 1'b0;
         end
         default: ;
      endcase
   end

   assign wpn_dq2  = 1'b1;
   assign hldn_dq3 = 1'b1;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter (GUARD_CYCLES=4, SYNC_STAGES=2, USER_TIMEOUT=16).
// Preemption expectations follow the JTAG_PREEMPT_EN build macro.
module tb_spi_flash_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic       jtag_csn, jtag_sck, jtag_sdi, jtag_sdo;
   logic       usr_req, usr_gnt, usr_abort;
   logic       usr_csn, usr_sck, usr_sdi, usr_sdo;
   logic       collision_clr, jtag_collision;
   logic [1:0] owner;
   logic       csn, sck, sdi_dq0, sdo_dq1, wpn_dq2, hldn_dq3;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   spi_flash_arbiter #(.GUARD_CYCLES(4), .SYNC_STAGES(2), .USER_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .jtag_csn(jtag_csn), .jtag_sck(jtag_sck), .jtag_sdi(jtag_sdi), .jtag_sdo(jtag_sdo),
      .usr_req(usr_req), .usr_gnt(usr_gnt), .usr_abort(usr_abort),
      .usr_csn(usr_csn), .usr_sck(usr_sck), .usr_sdi(usr_sdi), .usr_sdo(usr_sdo),
      .collision_clr(collision_clr), .jtag_collision(jtag_collision), .owner(owner),
      .csn(csn), .sck(sck), .sdi_dq0(sdi_dq0), .sdo_dq1(sdo_dq1),
      .wpn_dq2(wpn_dq2), .hldn_dq3(hldn_dq3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; jtag_csn = 1'b1; jtag_sck = 1'b0; jtag_sdi = 1'b0;
      usr_req = 1'b0; usr_csn = 1'b1; usr_sck = 1'b0; usr_sdi = 1'b0;
      collision_clr = 1'b0; sdo_dq1 = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({owner, usr_gnt, usr_abort, jtag_collision} !== 5'b01_000) begin
         failures++;
         $display("FAIL reset_state got owner=%b gnt=%b abort=%b coll=%b want 01 0 0 0",
                  owner, usr_gnt, usr_abort, jtag_collision);
      end
      checks++;
      if ({wpn_dq2, hldn_dq3, csn} !== 3'b111) begin
         failures++;
         $display("FAIL reset_pins got wpn=%b hldn=%b csn=%b want 1 1 1", wpn_dq2, hldn_dq3, csn);
      end
   endtask

   task automatic test_jtag_path();
      jtag_csn = 1'b0;
      for (int i = 0; i < 40; i++) begin
         jtag_sck = ~jtag_sck;
         jtag_sdi = 1'($urandom);
         sdo_dq1  = 1'($urandom);
         #1;
         checks++;
         if ({csn, sck, sdi_dq0, jtag_sdo, usr_sdo, usr_gnt, owner} !==
             {1'b0, jtag_sck, jtag_sdi, sdo_dq1, 1'b0, 1'b0, 2'b01}) begin
            failures++;
            $display("FAIL jtag_route[%0d] got csn=%b sck=%b sdi=%b jsdo=%b usdo=%b gnt=%b own=%b",
                     i, csn, sck, sdi_dq0, jtag_sdo, usr_sdo, usr_gnt, owner);
         end
         tick();
      end
      jtag_csn = 1'b1; jtag_sck = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_user_grant();
      usr_req = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         checks++;
         if (usr_gnt !== (k == 5)) begin
            failures++;
            $display("FAIL grant_latency cycle %0d got gnt=%b want %b", k, usr_gnt, (k == 5));
         end
      end
      usr_csn = 1'b0; usr_sck = 1'b1; usr_sdi = 1'b1; sdo_dq1 = 1'b1;
      #1;
      checks++;
      if ({csn, sck, sdi_dq0, usr_sdo, jtag_sdo, owner} !== 7'b0_1_1_1_0_10) begin
         failures++;
         $display("FAIL user_route got csn=%b sck=%b sdi=%b usdo=%b jsdo=%b own=%b want 0 1 1 1 0 10",
                  csn, sck, sdi_dq0, usr_sdo, jtag_sdo, owner);
      end
      tick(); tick();
      usr_csn = 1'b1; usr_sck = 1'b0; usr_sdi = 1'b0; usr_req = 1'b0;
      tick();
      checks++;
      if ({usr_gnt, csn, sck, sdi_dq0} !== 4'b0100) begin
         failures++;
         $display("FAIL release_pins got gnt=%b csn=%b sck=%b sdi=%b want 0 1 0 0",
                  usr_gnt, csn, sck, sdi_dq0);
      end
      for (int i = 0; i <= 4; i++) begin
         checks++;
         if (owner !== ((i < 4) ? 2'b00 : 2'b01)) begin
            failures++;
            $display("FAIL guard_j_owner step %0d got %b want %b", i, owner, ((i < 4) ? 2'b00 : 2'b01));
         end
         tick();
      end
   endtask

   task automatic test_jtag_during_guard();
      usr_req = 1'b1;
      tick();
      jtag_csn = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         checks++;
         if ({usr_gnt, owner, jtag_collision} !== 4'b0_01_0) begin
            failures++;
            $display("FAIL guard_u_preempt cycle %0d got gnt=%b own=%b coll=%b want 0 01 0",
                     k, usr_gnt, owner, jtag_collision);
         end
      end
      jtag_csn = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         checks++;
         if (usr_gnt !== (k == 8)) begin
            failures++;
            $display("FAIL fresh_guard cycle %0d got gnt=%b want %b", k, usr_gnt, (k == 8));
         end
      end
      usr_req = 1'b0;
      repeat (5) tick();
   endtask

   task automatic test_timeout();
      usr_req = 1'b1;
      repeat (5) tick();
      for (int k = 1; k <= 16; k++) begin
         tick();
         checks++;
         if ({usr_abort, usr_gnt} !== {(k == 16), (k < 16)}) begin
            failures++;
            $display("FAIL timeout cycle %0d got abort=%b gnt=%b want %b %b",
                     k, usr_abort, usr_gnt, (k == 16), (k < 16));
         end
      end
      checks++;
      if (owner !== 2'b00) begin
         failures++;
         $display("FAIL timeout_guard got owner=%b want 00", owner);
      end
      tick();
      checks++;
      if ({usr_abort, owner} !== 3'b0_00) begin
         failures++;
         $display("FAIL abort_width got abort=%b own=%b want 0 00", usr_abort, owner);
      end
      usr_req = 1'b0;
      repeat (4) tick();
      checks++;
      if (owner !== 2'b01) begin
         failures++;
         $display("FAIL timeout_return got owner=%b want 01", owner);
      end
   endtask

   task automatic test_collision();
      usr_req = 1'b1;
      repeat (5) tick();
      jtag_csn = 1'b0;
`ifdef JTAG_PREEMPT_EN
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++;
         if ({usr_abort, jtag_collision} !== {(k == 3), (k == 3)}) begin
            failures++;
            $display("FAIL preempt cycle %0d got abort=%b coll=%b want %b %b",
                     k, usr_abort, jtag_collision, (k == 3), (k == 3));
         end
      end
      checks++;
      if ({usr_gnt, owner, csn} !== 4'b0_00_1) begin
         failures++;
         $display("FAIL preempt_pins got gnt=%b own=%b csn=%b want 0 00 1", usr_gnt, owner, csn);
      end
      repeat (5) tick();
      checks++;
      if ({owner, csn} !== 3'b01_0) begin
         failures++;
         $display("FAIL preempt_jtag got own=%b csn=%b want 01 0", owner, csn);
      end
      jtag_csn = 1'b1; usr_req = 1'b0;
      repeat (4) tick();
`else
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++;
         if (jtag_collision !== (k == 3)) begin
            failures++;
            $display("FAIL collision_set cycle %0d got %b want %b", k, jtag_collision, (k == 3));
         end
      end
      collision_clr = 1'b1;
      tick();
      collision_clr = 1'b0;
      checks++;
      if ({jtag_collision, usr_gnt, owner, usr_abort} !== 5'b1_1_10_0) begin
         failures++;
         $display("FAIL collision_hold got coll=%b gnt=%b own=%b abort=%b want 1 1 10 0",
                  jtag_collision, usr_gnt, owner, usr_abort);
      end
      jtag_csn = 1'b1; usr_req = 1'b0;
      repeat (6) tick();
`endif
      collision_clr = 1'b1;
      tick();
      collision_clr = 1'b0;
      checks++;
      if ({jtag_collision, owner} !== 3'b0_01) begin
         failures++;
         $display("FAIL collision_clear got coll=%b own=%b want 0 01", jtag_collision, owner);
      end
   endtask

   task automatic test_reset_mid_user();
      usr_req = 1'b1;
      repeat (5) tick();
      checks++;
      if (usr_gnt !== 1'b1) begin
         failures++;
         $display("FAIL mid_user_grant got gnt=%b want 1", usr_gnt);
      end
`ifndef JTAG_PREEMPT_EN
      jtag_csn = 1'b0;
      repeat (3) tick();
      jtag_csn = 1'b1;
`endif
      rst = 1'b1; usr_req = 1'b0;
      tick();
      checks++;
      if ({owner, usr_gnt, jtag_collision, usr_abort, csn} !== 6'b01_0_0_0_1) begin
         failures++;
         $display("FAIL reset_mid_user got own=%b gnt=%b coll=%b abort=%b csn=%b want 01 0 0 0 1",
                  owner, usr_gnt, jtag_collision, usr_abort, csn);
      end
      rst = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_jtag_path();
      test_user_grant();
      test_jtag_during_guard();
      test_timeout();
      test_collision();
      test_reset_mid_user();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/spi_flash_arbiter.md
# spi_flash_arbiter

Shares the configuration SPI flash pins between the JTAG-to-SPI bridge (asynchronous, TCK-driven, cannot be stalled) and a fabric SPI master (clk domain, request/grant handshake). Sits between both masters and the flash pins or startup primitive, parks the pins on the JTAG path when idle, and enforces a chip-select-high guard interval on every ownership change. Reports collisions and timeouts to the fabric.

## Interface
- GUARD_CYCLES, 4: clk cycles with csn forced/held high between owners; legal range 1..255.
- SYNC_STAGES, 2: synchronizer depth for jtag_csn; legal range 2..4.
- USER_TIMEOUT, 65535: max clk cycles a user grant is held; 0 disables the timeout.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- jtag_csn  in  1  bridge chip select, asynchronous, active low.
- jtag_sck  in  1  bridge SPI clock (DRCK).
- jtag_sdi  in  1  bridge MOSI.
- jtag_sdo  out  1  MISO to the bridge TDO mux.
- usr_req  in  1  fabric request; held high for the whole transaction.
- usr_gnt  out  1  fabric grant.
- usr_abort  out  1  one-cycle pulse; grant revoked.
- usr_csn, usr_sck, usr_sdi  in  1 each  fabric SPI outputs.
- usr_sdo  out  1  MISO to the fabric master.
- collision_clr  in  1  clears jtag_collision.
- jtag_collision  out  1  sticky; JTAG accessed while not owner.
- owner  out  2  00 none (guard), 01 JTAG path, 10 user.
- csn, sck, sdi_dq0  out  1 each  flash pins.
- sdo_dq1  in  1  flash MISO.
- wpn_dq2, hldn_dq3  out  1 each  tied 1.

## Operation
- jtag_csn passes through SYNC_STAGES flops reset to 1. jtag_req_s = NOT synced output.
- States:
  - IDLE: pins routed combinationally from jtag_*; owner=01.
  - JTAG: pins routed from jtag_*; owner=01.
  - GUARD_U: pins still routed from jtag_*; owner=01.
  - USER: pins routed from usr_*; owner=10; usr_gnt=1.
  - GUARD_J: csn=1, sck=0, sdi_dq0=0; owner=00.
- Transitions:
  - IDLE: jtag_req_s → JTAG. Else usr_req → GUARD_U with counter loaded.
  - JTAG: !jtag_req_s → IDLE.
  - GUARD_U: jtag_req_s → JTAG; usr_req stays pending. usr_req dropped → IDLE. Counter expiry → USER.
  - USER: usr_req low → GUARD_J. Timeout expiry → GUARD_J with usr_abort pulse.
  - GUARD_J: counter expiry → IDLE.
- Priority: jtag_req_s beats usr_req in IDLE and GUARD_U.
- jtag_sdo=sdo_dq1 when owner=01, else 0. usr_sdo=sdo_dq1 in USER, else 0.
- Collision: jtag_req_s high in USER or GUARD_J sets jtag_collision. collision_clr clears it. A set and a clear in the same cycle: set wins.
- Guard counter: 8-bit, loaded with GUARD_CYCLES-1, exits at 0.
- Timeout counter: 16-bit, cleared on entry to USER, expires at USER_TIMEOUT-1.
- wpn_dq2 and hldn_dq3 are constant 1 in every state, including reset.

## Timing
- Reset values: IDLE, owner=01, usr_gnt=0, usr_abort=0, jtag_collision=0, sync flops=1, counters=0.
- Reset mid-USER: next cycle the state is IDLE and the pins return to the JTAG path. There is no guard.
- JTAG routing has zero clk latency. jtag_req_s lags jtag_csn by SYNC_STAGES to SYNC_STAGES+1 cycles.
- usr_req high in IDLE → usr_gnt high exactly GUARD_CYCLES+1 cycles later, provided there is no JTAG activity.
- usr_req low in USER → usr_gnt low the next cycle. owner=00 for GUARD_CYCLES cycles, then 01.
- The fabric master holds usr_csn high when it raises or drops usr_req. The block does not check this.
- Simultaneous usr_req and jtag_req_s rising in IDLE: JTAG wins. Grant timing for usr_req restarts from IDLE.

## Configuration
- JTAG_PREEMPT_EN defined:
  - jtag_req_s in USER → USER exits to GUARD_J next cycle.
  - usr_abort pulses for one cycle and usr_gnt drops.
  - The flash sees csn forced high.
  - jtag_collision is still set.
  - After the guard, IDLE routes to JTAG.
- JTAG_PREEMPT_EN undefined:
  - The user keeps ownership until release or timeout.
  - Only jtag_collision is set.

## Test plan
- Reset, then jtag_csn low for 40 TCK → owner=01, csn follows jtag_csn, sdo_dq1 visible on jtag_sdo, usr_gnt=0.
- GUARD_CYCLES=4, usr_req high in IDLE → usr_gnt high cycle 5, usr_* reach pins; usr_req low → owner=00 for 4 cycles with csn=1, then 01.
- jtag_csn falls during GUARD_U → state JTAG, usr_gnt stays 0; JTAG ends → IDLE → usr_gnt after a fresh guard.
- USER_TIMEOUT=16, usr_req held → usr_abort one pulse at cycle 16 of USER, usr_gnt low, GUARD_J.
- jtag_csn low during USER: without the macro, jtag_collision=1 and owner stays 10; with JTAG_PREEMPT_EN, usr_abort pulse, GUARD_J, then owner=01. Then collision_clr → jtag_collision=0.
- rst asserted mid-USER → next cycle owner=01, usr_gnt=0, jtag_collision=0.
